hweval_montgomery_sweep: RTL and testbench
==========================================

Name: hweval_montgomery_sweep

Overview:
Parametrised on-board evaluation harness for modular-multiplier cores such as montgomery. It generates pseudo-random operand sets from a 32-bit LFSR and drives NUM_OPS start/done transactions into an external DUT. Each result is compressed into a MISR signature, and a single data_ok / fail pin pair is exposed for the FPGA board. Unlike the fixed toggle stimulus it replaces, it is width-generic, sequences multiple operations, enforces operand validity and detects DUT hangs.

Parameters:
WIDTH, 512, operand/result width; must be a multiple of 32 and at least 64
NUM_OPS, 16, transactions per run; must be at least 1
SEED, 32'h0000_0001, LFSR seed; a value of 0 is replaced by 1
TIMEOUT, 4096, maximum cycles allowed in WAIT per transaction
EXPECTED_SIG, {WIDTH{1'b0}}, golden MISR value compared at the end of a run

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
run  in  1  level-sensitive run request
dut_start  out  1  one-cycle start pulse to the DUT
dut_a  out  WIDTH  operand A
dut_b  out  WIDTH  operand B
dut_m  out  WIDTH  modulus
dut_result  in  WIDTH  DUT result
dut_done  in  1  DUT completion
busy  out  1  high in every state except IDLE, DONE and FAIL
data_ok  out  1  run finished and signature matches
fail  out  1  run finished with a mismatch or a timeout
timeout  out  1  fail was caused by a timeout
op_count  out  $clog2(NUM_OPS+1)  transactions absorbed so far
signature  out  WIDTH  current MISR value

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; all outputs 0; lfsr=SEED; operand regs 0; count and timer 0.
- FSM: IDLE, FILL, START, WAIT, ACC, CHECK, DONE, FAIL. All transitions occur on posedge clk.
- IDLE: when run=1, load lfsr=SEED, signature=0, op_count=0, word counter=0, then go to FILL.
- FILL: lasts 3*WIDTH/32 cycles.
  - Each cycle: if lfsr[0]=1, lfsr_n = (lfsr>>1) ^ 32'h8020_0003; otherwise lfsr_n = lfsr>>1.
  - lfsr_n shifts into the LSB end of the target register: reg = {reg[WIDTH-33:0], lfsr_n}.
  - The first WIDTH/32 words go to A, the next WIDTH/32 to B, the last WIDTH/32 to M.
- Operand fix-up: dut_a[WIDTH-1]=0, dut_b[WIDTH-1]=0, dut_m[WIDTH-1]=1, dut_m[0]=1. This holds combinationally on the outputs, so m is odd and a,b < m.
- START: dut_start=1 for exactly this one cycle. Operands are stable from START until ACC completes. Timer is cleared. Next state is WAIT.
- WAIT:
  - If dut_done=1, go to ACC. The result is captured in the same cycle dut_done is seen.
  - Otherwise the timer increments. When timer reaches TIMEOUT-1 with no done, go to FAIL with timeout=1.
  - dut_done is ignored in every state other than WAIT.
- ACC:
  - signature = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ captured_result, i.e. rotate left by 1, then XOR.
  - op_count increments.
  - If op_count (new value) equals NUM_OPS, go to CHECK; otherwise go to FILL. The lfsr continues from its current value and is not reseeded.
- CHECK: one cycle. If signature equals EXPECTED_SIG, go to DONE, else go to FAIL.
- DONE: data_ok=1. FAIL: fail=1.
  - Both states hold until run=0, then return to IDLE. In IDLE, data_ok, fail and timeout clear.
  - signature and op_count stay readable until the next run starts.
- run dropping mid-run is ignored; the run completes. A new run requires run to go 0 then 1.
- resetn asserted mid-operation aborts immediately to the reset values. dut_start drops asynchronously.
- Per-transaction latency: 3*WIDTH/32 + 1 (START) + (cycles in WAIT) + 1 (ACC).

Decomposition:
- Package hweval_pkg holds:
  - the state enum encoding (3 bits);
  - LFSR_TAPS = 32'h8020_0003;
  - LFSR_W = 32.
- Sub-module hweval_lfsr32: seed load, step enable, 32-bit output. It is reused by future hweval_* harnesses.
- The MISR and FSM stay inline.

Test Plan:
1. WIDTH=64, NUM_OPS=2, SEED=1, DUT model returns a^b^m with 3-cycle done latency, run=1 -> first dut_a=64'h0020_0003_C030_0002 and dut_b=64'h6018_0001_B02C_0003 at the first START; dut_start high exactly 1 cycle; op_count goes 1 then 2.
2. Same setup with EXPECTED_SIG set to the signature computed by the model -> data_ok=1 and fail=0 after CHECK; data_ok clears one cycle after run=0.
3. Same setup with EXPECTED_SIG wrong by one bit -> fail=1, timeout=0, data_ok=0.
4. DUT never asserts done, TIMEOUT=8 -> fail=1 and timeout=1 after 8 WAIT cycles; op_count=0.
5. Spurious dut_done pulses during FILL and START -> ignored; signature is identical to scenario 2.
6. resetn pulsed low during WAIT of op 1 -> all outputs 0 asynchronously; the following run reproduces scenario 2's operands and signature exactly.

Source files
------------

// File: rtl/hweval_pkg.sv
// Shared state encoding and LFSR helpers for the hweval_* on-board evaluation harnesses.
package hweval_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACC   = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // An all-zero seed would lock the LFSR up, so it is promoted to 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction
endpackage

// File: rtl/hweval_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable; load wins over step.
module hweval_lfsr32
  import hweval_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = seed_fix(seed);
    else if (step) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= seed_fix(RST_SEED);
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule

// File: rtl/hweval_montgomery_sweep.sv
// Evaluation harness: fills LFSR operands, runs NUM_OPS start/done transactions on an
// external modular multiplier, folds results into a MISR and reports pass/fail/timeout.
module hweval_montgomery_sweep
  import hweval_pkg::*;
#(
  parameter int               WIDTH        = 512,
  parameter int               NUM_OPS      = 16,
  parameter logic [31:0]      SEED         = 32'h0000_0001,
  parameter int               TIMEOUT      = 4096,
  parameter logic [WIDTH-1:0] EXPECTED_SIG = {WIDTH{1'b0}},
  localparam int              CW           = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  output logic             dut_start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic [WIDTH-1:0] dut_m,
  input  logic [WIDTH-1:0] dut_result,
  input  logic             dut_done,
  output logic             busy,
  output logic             data_ok,
  output logic             fail,
  output logic             timeout,
  output logic [CW-1:0]    op_count,
  output logic [WIDTH-1:0] signature
);
  localparam int NW       = WIDTH / 32;
  localparam int FILL_CYC = 3 * NW;
  localparam int WCW      = $clog2(FILL_CYC);
  localparam int TW       = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d, sig_q, sig_d;
  logic [CW-1:0]    opc_q, opc_d;
  logic             to_q, to_d;
  logic             lfsr_load, lfsr_step_en;
  logic [LFSR_W-1:0] lfsr_q, lfsr_n;

  hweval_lfsr32 #(.RST_SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (resetn),
    .load  (lfsr_load),
    .step  (lfsr_step_en),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  // The word shifted in this cycle is the value the LFSR advances to.
  assign lfsr_n = lfsr_step(lfsr_q);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    timer_d      = timer_q;
    a_d          = a_q;
    b_d          = b_q;
    m_d          = m_q;
    res_d        = res_q;
    sig_d        = sig_q;
    opc_d        = opc_q;
    to_d         = to_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          lfsr_load = 1'b1;
          sig_d     = '0;
          opc_d     = '0;
          wcnt_d    = '0;
          to_d      = 1'b0;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        lfsr_step_en = 1'b1;
        // Fix-up is folded into the load: the MSB forced here is shifted out by the next
        // word, so only the final word's value survives, and the ports read 0 out of reset.
        if (wcnt_q < WCW'(NW)) begin
          a_d            = {a_q[WIDTH-33:0], lfsr_n};
          a_d[WIDTH-1]   = 1'b0;
        end else if (wcnt_q < WCW'(2 * NW)) begin
          b_d            = {b_q[WIDTH-33:0], lfsr_n};
          b_d[WIDTH-1]   = 1'b0;
        end else begin
          m_d            = {m_q[WIDTH-33:0], lfsr_n};
          if (wcnt_q == WCW'(FILL_CYC - 1)) begin
            m_d[WIDTH-1] = 1'b1;
            m_d[0]       = 1'b1;
          end
        end
        if (wcnt_q == WCW'(FILL_CYC - 1)) begin
          wcnt_d  = '0;
          state_d = ST_START;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end

      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (dut_done) begin
          res_d   = dut_result;
          state_d = ST_ACC;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = ST_FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_ACC: begin
        sig_d   = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ res_q;
        opc_d   = opc_q + 1'b1;
        state_d = (opc_d == CW'(NUM_OPS)) ? ST_CHECK : ST_FILL;
      end

      ST_CHECK: state_d = (sig_q == EXPECTED_SIG) ? ST_DONE : ST_FAIL;

      ST_DONE,
      ST_FAIL: if (!run) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      sig_q   <= '0;
      opc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      sig_q   <= sig_d;
      opc_q   <= opc_d;
      to_q    <= to_d;
    end
  end

  assign dut_start = (state_q == ST_START);
  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign dut_m     = m_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);
  assign data_ok   = (state_q == ST_DONE);
  assign fail      = (state_q == ST_FAIL);
  assign timeout   = to_q && (state_q == ST_FAIL);
  assign op_count  = opc_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_hweval_montgomery_sweep.sv
// Bench: four harness instances (pass, wrong golden, hang, 128-bit with zero seed) against a
// behavioural LFSR/MISR model and a randomized-latency multiplier stand-in (a^b^m).
module tb_hweval_montgomery_sweep;
  logic clk, resetn, run;

  logic        a_start, a_busy, a_ok, a_fail, a_to;
  logic [63:0] a_a, a_b, a_m, a_sig;
  logic [1:0]  a_opc;
  logic        b_start, b_busy, b_ok, b_fail, b_to;
  logic [63:0] b_a, b_b, b_m, b_sig;
  logic [1:0]  b_opc;
  logic        c_start, c_busy, c_ok, c_fail, c_to;
  logic [63:0] c_a, c_b, c_m, c_sig;
  logic [1:0]  c_opc;
  logic         d_start, d_busy, d_ok, d_fail, d_to;
  logic [127:0] d_a, d_b, d_m, d_sig;
  logic [2:0]   d_opc;

  logic         ab_done, c_done, d_done;
  logic [63:0]  ab_res, c_res;
  logic [127:0] d_res;

  int checks, failures;
  bit spur_en;
  int fixed_lat;
  bit ra_busy, rd_busy;
  int ra_cnt, rd_cnt;
  logic [63:0]  ra_val;
  logic [127:0] rd_val;

  int st_cnt, st_consec, st_max, c_busy_cnt, prev_opc;
  bit got_first;
  logic [63:0] first_a, first_b;
  int opc_hist[$];

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [127:0] model_sig(input int w, input int n, input logic [31:0] seed);
    logic [31:0]  s;
    logic [127:0] one, mask, a, b, m, sig;
    one  = 128'd1;
    mask = (one << w) - one;
    s    = (seed == 32'd0) ? 32'd1 : seed;
    sig  = '0;
    for (int op = 0; op < n; op++) begin
      a = '0; b = '0; m = '0;
      for (int i = 0; i < w / 32; i++) begin s = lstep(s); a = ((a << 32) | {96'd0, s}) & mask; end
      for (int i = 0; i < w / 32; i++) begin s = lstep(s); b = ((b << 32) | {96'd0, s}) & mask; end
      for (int i = 0; i < w / 32; i++) begin s = lstep(s); m = ((m << 32) | {96'd0, s}) & mask; end
      a = a & ~(one << (w - 1));
      b = b & ~(one << (w - 1));
      m = m | (one << (w - 1)) | one;
      sig = (((sig << 1) | (sig >> (w - 1))) & mask) ^ a ^ b ^ m;
    end
    return sig;
  endfunction

  localparam logic [127:0] SIG64  = model_sig(64, 2, 32'd1);
  localparam logic [63:0]  GOLD   = SIG64[63:0];
  localparam logic [127:0] SIG128 = model_sig(128, 3, 32'd0);
  localparam int C_BUSY_EXP = 3 * 64 / 32 + 1 + 8;

  hweval_montgomery_sweep #(.WIDTH(64), .NUM_OPS(2), .SEED(32'd1), .TIMEOUT(4096),
                            .EXPECTED_SIG(GOLD)) u_dut_a (
    .clk(clk), .resetn(resetn), .run(run), .dut_start(a_start), .dut_a(a_a), .dut_b(a_b),
    .dut_m(a_m), .dut_result(ab_res), .dut_done(ab_done), .busy(a_busy), .data_ok(a_ok),
    .fail(a_fail), .timeout(a_to), .op_count(a_opc), .signature(a_sig));

  hweval_montgomery_sweep #(.WIDTH(64), .NUM_OPS(2), .SEED(32'd1), .TIMEOUT(4096),
                            .EXPECTED_SIG(GOLD ^ 64'd1)) u_dut_b (
    .clk(clk), .resetn(resetn), .run(run), .dut_start(b_start), .dut_a(b_a), .dut_b(b_b),
    .dut_m(b_m), .dut_result(ab_res), .dut_done(ab_done), .busy(b_busy), .data_ok(b_ok),
    .fail(b_fail), .timeout(b_to), .op_count(b_opc), .signature(b_sig));

  hweval_montgomery_sweep #(.WIDTH(64), .NUM_OPS(2), .SEED(32'd1), .TIMEOUT(8)) u_dut_c (
    .clk(clk), .resetn(resetn), .run(run), .dut_start(c_start), .dut_a(c_a), .dut_b(c_b),
    .dut_m(c_m), .dut_result(c_res), .dut_done(c_done), .busy(c_busy), .data_ok(c_ok),
    .fail(c_fail), .timeout(c_to), .op_count(c_opc), .signature(c_sig));

  hweval_montgomery_sweep #(.WIDTH(128), .NUM_OPS(3), .SEED(32'd0), .TIMEOUT(4096),
                            .EXPECTED_SIG(128'd0)) u_dut_d (
    .clk(clk), .resetn(resetn), .run(run), .dut_start(d_start), .dut_a(d_a), .dut_b(d_b),
    .dut_m(d_m), .dut_result(d_res), .dut_done(d_done), .busy(d_busy), .data_ok(d_ok),
    .fail(d_fail), .timeout(d_to), .op_count(d_opc), .signature(d_sig));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick_lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
  endfunction

  // One negedge step plus the multiplier stand-ins; A and B see identical stimulus.
  task automatic tick();
    @(negedge clk);
    if (ra_busy) begin
      if (ra_cnt == 0) begin ab_done = 1'b1; ab_res = ra_val; ra_busy = 1'b0; end
      else begin ab_done = 1'b0; ra_cnt--; end
    end else begin
      ab_done = spur_en && ($urandom_range(0, 2) == 0);
      ab_res  = {$urandom, $urandom};
      if (a_start) begin ra_busy = 1'b1; ra_val = a_a ^ a_b ^ a_m; ra_cnt = pick_lat(); end
    end
    if (rd_busy) begin
      if (rd_cnt == 0) begin d_done = 1'b1; d_res = rd_val; rd_busy = 1'b0; end
      else begin d_done = 1'b0; rd_cnt--; end
    end else begin
      d_done = spur_en && ($urandom_range(0, 2) == 0);
      d_res  = {$urandom, $urandom, $urandom, $urandom};
      if (d_start) begin rd_busy = 1'b1; rd_val = d_a ^ d_b ^ d_m; rd_cnt = pick_lat(); end
    end
  endtask

  task automatic run_to_end();
    int cyc;
    bit fin;
    st_cnt = 0; st_consec = 0; st_max = 0; got_first = 1'b0; c_busy_cnt = 0;
    opc_hist.delete();
    prev_opc = int'(a_opc);
    run = 1'b1; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 2000) begin
      tick(); cyc++;
      if (a_start) begin
        st_consec++;
        if (st_consec == 1) st_cnt++;
        if (st_consec > st_max) st_max = st_consec;
        if (!got_first) begin first_a = a_a; first_b = a_b; got_first = 1'b1; end
      end else st_consec = 0;
      if (int'(a_opc) != prev_opc) begin
        if (a_opc != 2'd0) opc_hist.push_back(int'(a_opc));
        prev_opc = int'(a_opc);
      end
      if (c_busy) c_busy_cnt++;
      fin = (a_ok | a_fail) && (b_ok | b_fail) && c_fail && (d_ok | d_fail);
    end
    checks++;
    if (!fin) begin failures++; $display("FAIL run_complete got=not finished required=finished within 2000 cycles"); end
  endtask

  task automatic drop_run();
    run = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({a_start, a_busy, a_ok, a_fail, a_to} !== 5'b0 || a_opc !== 2'd0 || a_sig !== 64'd0 ||
        a_a !== 64'd0 || a_b !== 64'd0 || a_m !== 64'd0) begin
      failures++; $display("FAIL reset_a got sig=%h a=%h m=%h opc=%0d required all zero", a_sig, a_a, a_m, a_opc);
    end
    checks++;
    if ({b_start, b_busy, b_ok, b_fail, b_to, c_start, c_busy, c_ok, c_fail, c_to,
         d_start, d_busy, d_ok, d_fail, d_to} !== 15'b0 || (b_a | b_b | b_m | b_sig | c_a | c_b | c_m | c_sig) !== 64'd0 ||
        (d_a | d_b | d_m | d_sig) !== 128'd0 || {b_opc, c_opc, d_opc} !== 7'd0) begin
      failures++; $display("FAIL reset_others got=nonzero output required=all zero");
    end
    tick(); tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_start !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got busy=%b start=%b required 0 0", a_busy, a_start);
    end
  endtask

  task automatic test_sequence();
    fixed_lat = 3;
    run_to_end();
    checks++;
    if (first_a !== 64'h0020_0003_C030_0002) begin failures++; $display("FAIL first_a got=%h required=%h", first_a, 64'h0020_0003_C030_0002); end
    checks++;
    if (first_b !== 64'h6018_0001_B02C_0003) begin failures++; $display("FAIL first_b got=%h required=%h", first_b, 64'h6018_0001_B02C_0003); end
    checks++;
    if (st_max != 1 || st_cnt != 2) begin failures++; $display("FAIL start_pulse got width=%0d count=%0d required 1 2", st_max, st_cnt); end
    checks++;
    if (opc_hist.size() != 2 || opc_hist[0] != 1 || opc_hist[1] != 2) begin
      failures++; $display("FAIL op_count_seq got size=%0d required sequence 1,2", opc_hist.size());
    end
    checks++;
    if (a_ok !== 1'b1 || a_fail !== 1'b0 || a_sig !== GOLD) begin
      failures++; $display("FAIL pass_run got ok=%b fail=%b sig=%h required 1 0 %h", a_ok, a_fail, a_sig, GOLD);
    end
    checks++;
    if (b_fail !== 1'b1 || b_to !== 1'b0 || b_ok !== 1'b0) begin
      failures++; $display("FAIL bad_golden got fail=%b to=%b ok=%b required 1 0 0", b_fail, b_to, b_ok);
    end
    checks++;
    if (c_fail !== 1'b1 || c_to !== 1'b1 || c_opc !== 2'd0 || c_busy_cnt != C_BUSY_EXP) begin
      failures++; $display("FAIL hang got fail=%b to=%b opc=%0d busy_cycles=%0d required 1 1 0 %0d", c_fail, c_to, c_opc, c_busy_cnt, C_BUSY_EXP);
    end
    checks++;
    if (d_sig !== SIG128 || d_opc !== 3'd3 || d_fail !== (SIG128 != 128'd0) || d_ok !== (SIG128 == 128'd0)) begin
      failures++; $display("FAIL wide_seed0 got sig=%h opc=%0d required sig=%h opc=3", d_sig, d_opc, SIG128);
    end
    run = 1'b0;
    tick();
    checks++;
    if (a_ok !== 1'b0 || a_sig !== GOLD || a_opc !== 2'd2 || c_to !== 1'b0 || c_fail !== 1'b0) begin
      failures++; $display("FAIL run_drop got ok=%b sig=%h opc=%0d c_to=%b required 0 %h 2 0", a_ok, a_sig, a_opc, c_to, GOLD);
    end
    tick();
  endtask

  task automatic test_spurious();
    spur_en = 1'b1;
    fixed_lat = -1;
    run_to_end();
    checks++;
    if (a_sig !== GOLD || a_ok !== 1'b1 || first_a !== 64'h0020_0003_C030_0002) begin
      failures++; $display("FAIL spurious_done got sig=%h ok=%b required %h 1", a_sig, a_ok, GOLD);
    end
    checks++;
    if (d_sig !== SIG128) begin failures++; $display("FAIL spurious_wide got=%h required=%h", d_sig, SIG128); end
    spur_en = 1'b0;
    drop_run();
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    bit prev;
    fixed_lat = 4;
    run = 1'b1; n = 0; cyc = 0; prev = 1'b0;
    while (n < 2 && cyc < 300) begin
      tick(); cyc++;
      if (a_start && !prev) n++;
      prev = a_start;
    end
    tick();
    checks++;
    if (n < 2 || a_busy !== 1'b1 || a_opc !== 2'd1) begin
      failures++; $display("FAIL pre_reset got starts=%0d busy=%b opc=%0d required 2 1 1", n, a_busy, a_opc);
    end
    #2 resetn = 1'b0;
    run = 1'b0;
    ra_busy = 1'b0; rd_busy = 1'b0; ab_done = 1'b0; d_done = 1'b0;
    #1;
    checks++;
    if ({a_start, a_busy, a_ok, a_fail, a_to} !== 5'b0 || a_opc !== 2'd0 || a_sig !== 64'd0 ||
        a_a !== 64'd0 || a_b !== 64'd0 || a_m !== 64'd0 || d_sig !== 128'd0 || d_busy !== 1'b0) begin
      failures++; $display("FAIL async_reset got start=%b busy=%b sig=%h opc=%0d required all zero", a_start, a_busy, a_sig, a_opc);
    end
    tick();
    resetn = 1'b1;
    tick();
    run_to_end();
    checks++;
    if (first_a !== 64'h0020_0003_C030_0002 || first_b !== 64'h6018_0001_B02C_0003) begin
      failures++; $display("FAIL rerun_operands got a=%h b=%h", first_a, first_b);
    end
    checks++;
    if (a_sig !== GOLD || a_ok !== 1'b1 || a_fail !== 1'b0) begin
      failures++; $display("FAIL rerun_sig got sig=%h ok=%b required %h 1", a_sig, a_ok, GOLD);
    end
    drop_run();
  endtask

  initial begin
    checks = 0; failures = 0;
    run = 1'b0; spur_en = 1'b0; fixed_lat = 3;
    ra_busy = 1'b0; rd_busy = 1'b0; ra_cnt = 0; rd_cnt = 0;
    ab_done = 1'b0; ab_res = '0; d_done = 1'b0; d_res = '0;
    c_done = 1'b0; c_res = '0;
    test_reset();
    test_sequence();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
